// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts a sync pattern, then assembles an MSB-first payload and checks even parity.
// Latency: data_out/par_err/valid are registered on the edge that samples the parity bit.
// Backpressure: none; ce only qualifies which edges sample si, and valid is never held off.
module serial_frame_rx #(
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  parameter int                DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              si,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              sync_lock,
  output logic [7:0]        frame_cnt
);

  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} state_t;

  state_t              state, state_nxt;
  // Only the older SYNC_W-1 window bits need storage; the newest bit is si itself.
  logic [SYNC_W-2:0]   hist;
  logic [FILL_W-1:0]   fill;
  logic [CNT_W-1:0]    bitcnt;
  logic [DATA_W-1:0]   data_sr;
  logic                acc;
  logic [SYNC_W-1:0]   win_shift;
  logic                sync_hit;
  logic                last_bit;
  logic                par_bad;

  assign win_shift = {hist, si};
  assign sync_hit  = (fill >= FILL_W'(SYNC_W - 1)) && (win_shift == SYNC_PAT);
  assign last_bit  = (bitcnt == CNT_W'(DATA_W - 1));
  assign par_bad   = acc ^ si;
  assign sync_lock = (state != HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        HUNT:    if (sync_hit) state_nxt = PAYLOAD;
        PAYLOAD: if (last_bit) state_nxt = PARITY;
        PARITY:  state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      bitcnt    <= '0;
      data_sr   <= '0;
      acc       <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      valid <= 1'b0;
      if (ce) begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              hist    <= '0;
              fill    <= '0;
              bitcnt  <= '0;
              data_sr <= '0;
              acc     <= 1'b0;
            end else begin
              hist <= win_shift[SYNC_W-2:0];
              if (fill != FILL_W'(SYNC_W)) fill <= fill + FILL_W'(1);
            end
          end
          PAYLOAD: begin
            data_sr <= (data_sr << 1) | DATA_W'(si);
            acc     <= acc ^ si;
            bitcnt  <= bitcnt + CNT_W'(1);
          end
          PARITY: begin
            data_out <= data_sr;
            par_err  <= par_bad;
            valid    <= 1'b1;
            if (!par_bad) frame_cnt <= frame_cnt + 8'd1;
            // A finished frame must not seed the next sync search.
            hist <= '0;
            fill <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized and directed bench for serial_frame_rx, checked every cycle against a queue-based frame model.
module tb_serial_frame_rx;

  localparam int          SYNC_W   = 4;
  localparam logic [3:0]  SYNC_PAT = 4'b1011;
  localparam int          DATA_W   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic       si  = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       par_err;
  logic       sync_lock;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  serial_frame_rx #(.SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .si(si),
    .data_out(data_out), .valid(valid), .par_err(par_err),
    .sync_lock(sync_lock), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bits seen since hunting began, and payload bits once locked.
  bit         hunt_q[$];
  bit         pay_q[$];
  bit         locked;
  logic [7:0] m_data;
  bit         m_perr;
  bit         m_valid;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function void model_reset();
    hunt_q.delete();
    pay_q.delete();
    locked  = 0;
    m_data  = 8'h00;
    m_perr  = 0;
    m_valid = 0;
    m_cnt   = 0;
  endfunction

  function void model_bit(input bit b);
    int v;
    int ones;
    m_valid = 0;
    if (!locked) begin
      hunt_q.push_back(b);
      if (hunt_q.size() >= SYNC_W) begin
        v = 0;
        for (int i = hunt_q.size() - SYNC_W; i < hunt_q.size(); i++) v = v * 2 + int'(hunt_q[i]);
        if (v == int'(SYNC_PAT)) begin
          locked = 1;
          hunt_q.delete();
          pay_q.delete();
        end
      end
    end else if (pay_q.size() < DATA_W) begin
      pay_q.push_back(b);
    end else begin
      v = 0;
      ones = int'(b);
      foreach (pay_q[i]) begin
        v = v * 2 + int'(pay_q[i]);
        ones += int'(pay_q[i]);
      end
      m_data  = 8'(v);
      m_perr  = (ones % 2) != 0;
      m_valid = 1;
      if (!m_perr) m_cnt = (m_cnt + 1) % 256;
      locked = 0;
      hunt_q.delete();
      pay_q.delete();
    end
  endfunction

  task automatic check_all();
    check("valid",     32'(valid),     32'(m_valid));
    check("data_out",  32'(data_out),  32'(m_data));
    check("par_err",   32'(par_err),   32'(m_perr));
    check("sync_lock", 32'(sync_lock), 32'(locked));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic step(input logic c, input logic b);
    @(negedge clk);
    ce = c;
    si = b;
    @(posedge clk);
    if (c) model_bit(b);
    else   m_valid = 0;
    #1;
    if (valid) vcnt++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
  endtask

  task automatic send_bit(input logic b, input int gap_pct);
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) step(1'b0, 1'($urandom));
    step(1'b1, b);
  endtask

  // Sync + payload MSB-first + parity; g4 idle cycles after payload bit 4, gpar before parity.
  task automatic send_frame(input logic [7:0] d, input logic p, input int g4, input int gpar, input int gap_pct);
    for (int i = SYNC_W - 1; i >= 0; i--) send_bit(SYNC_PAT[i], gap_pct);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], gap_pct);
      if (i == 4) idle(g4);
    end
    idle(gpar);
    send_bit(p, gap_pct);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ce  = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Good frame
    v0 = vcnt;
    send_frame(8'hA5, 1'b0, 0, 0, 0);
    check("t1_pulses", 32'(vcnt - v0), 32'd1);
    check("t1_data", 32'(data_out), 32'hA5);

    // Parity error: word still delivered, count unchanged
    v0 = vcnt;
    send_frame(8'hA5, 1'b1, 0, 0, 0);
    check("t2_pulses", 32'(vcnt - v0), 32'd1);
    check("t2_perr", 32'(par_err), 32'd1);
    check("t2_cnt", 32'(frame_cnt), 32'd1);

    // Noise and overlapping sync: 0,0,1,0,1,1 locks on its 6th bit
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("t3_prelock", 32'(sync_lock), 32'd0);
    step(1'b1, 1'b1);
    check("t3_lock", 32'(sync_lock), 32'd1);
    for (int i = 7; i >= 0; i--) step(1'b1, d_3c(i));
    step(1'b1, 1'b0);
    check("t3_data", 32'(data_out), 32'h3C);

    // ce gaps inside the frame
    v0 = vcnt;
    send_frame(8'hA5, 1'b0, 3, 2, 0);
    check("t4_pulses", 32'(vcnt - v0), 32'd1);
    check("t4_data", 32'(data_out), 32'hA5);

    // Reset mid-frame after payload bit 5
    v0 = vcnt;
    for (int i = SYNC_W - 1; i >= 0; i--) step(1'b1, SYNC_PAT[i]);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom));
    pulse_reset();
    check("t5_nopulse", 32'(vcnt - v0), 32'd0);
    send_frame(8'h5A, 1'b0, 0, 0, 0);
    check("t5_data", 32'(data_out), 32'h5A);
    check("t5_cnt", 32'(frame_cnt), 32'd1);

    // 256 back-to-back frames wrap the counter
    pulse_reset();
    v0 = vcnt;
    for (int f = 0; f < 256; f++) send_frame(8'hFF, 1'b0, 0, 0, 0);
    check("t6_pulses", 32'(vcnt - v0), 32'd256);
    check("t6_wrap", 32'(frame_cnt), 32'd0);

    // Random frames with noise prefixes, random parity and random ce gaps
    for (int f = 0; f < 80; f++) begin
      for (int n = $urandom_range(5); n > 0; n--) send_bit(1'($urandom), 20);
      d = 8'($urandom);
      send_frame(d, ($urandom_range(3) == 0) ? ~(^d) : ^d, 0, 0, 25);
      if ($urandom_range(15) == 0) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic d_3c(input int i);
    logic [7:0] w;
    w = 8'h3C;
    return w[i];
  endfunction

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver that consumes the 1-bit output stream of the 4-bit serial shift stage and turns it into parallel data words. It hunts for a fixed sync pattern, then assembles a DATA_W-bit payload MSB-first and checks a trailing even-parity bit. It presents each completed word with a one-cycle valid strobe. It sits directly downstream of the shift register and shares its clock and clock-enable.

## Interface

**Parameters**
- SYNC_W, 4: sync pattern length in bits (2..8).
- SYNC_PAT, 4'b1011: sync pattern, compared MSB-first (first received bit = MSB).
- DATA_W, 8: payload width in bits (1..16).

**Ports**
- clk  input  1  single clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  bit-enable; si is sampled only on edges where ce=1.
- si  input  1  serial data in, driven by the upstream shift stage's so.
- data_out  output  DATA_W  last received payload word.
- valid  output  1  one-cycle strobe: data_out and par_err are updated this cycle.
- par_err  output  1  parity result of the last frame (1 = mismatch).
- sync_lock  output  1  high while in PAYLOAD or PARITY.
- frame_cnt  output  8  count of good (parity-OK) frames; wraps modulo 256.

## Operation

**States:** HUNT, PAYLOAD, PARITY. Reset state is HUNT.

**ce gating**
- On edges with ce=0, every register holds.
- The exception is valid, which always deasserts on the following edge.

**HUNT**
- Each ce-qualified bit shifts into a SYNC_W-bit window: window <= {window[SYNC_W-2:0], si}.
- A fill counter saturates at SYNC_W.
- A match is declared on the edge where the fill count (including the current bit) reaches at least SYNC_W and {window[SYNC_W-2:0], si} == SYNC_PAT.
- On a match: go to PAYLOAD, clear the bit counter, clear the data shift register.
- Overlapping patterns are detected. For example, with SYNC_PAT=1011, the stream 1,0,1,0,1,1 matches on its 6th bit.

**PAYLOAD**
- Each ce-qualified bit shifts into the data register MSB-first.
- The running XOR of the bits is accumulated.
- After the DATA_W-th bit, go to PARITY.

**PARITY**
- The next ce-qualified bit is the parity bit. On that edge:
  - data_out <= assembled word.
  - par_err <= XOR(payload bits, parity bit), so even parity overall gives 0.
  - valid <= 1.
  - frame_cnt increments only if there is no parity error. 255 wraps to 0.
- The state returns to HUNT with the window and fill counter cleared. Bits from a finished frame never contribute to the next sync match.

**Output registers**
- data_out and par_err hold their values until the next completed frame.
- A parity error does not suppress data_out or valid.

**Reset, asserted at any time (including mid-frame)**
- Immediately: state=HUNT; window, fill count, bit counter and accumulator cleared.
- Outputs: data_out=0, valid=0, par_err=0, sync_lock=0, frame_cnt=0.
- No partial frame is emitted after reset.

## Timing

**Latency**
- valid rises on the rising edge that samples the parity bit with ce=1.
- valid is high for exactly one clk cycle, regardless of ce in that cycle.

**sync_lock**
- Rises on the edge that samples the last sync bit.
- Falls on the edge that samples the parity bit, i.e. the same edge where valid rises.

**Frame length**
- Minimum frame is SYNC_W + DATA_W + 1 ce-qualified bits (13 with defaults).
- Back-to-back frames with no gap bits are received without loss.

**Outputs and boundaries**
- All outputs are registered; there is no combinational path from si or ce to any output.
- ce may be low for any number of cycles at any point in a frame. The result must be identical to the gap-free stream.
- When reset deasserts, the first ce-qualified edge after deassertion is treated as the first HUNT bit.

## Test plan

1. **Good frame.** After reset, ce=1, send 1,0,1,1, then 0xA5 MSB-first (1,0,1,0,0,1,0,1), then parity 0. Required: valid pulses once on the 13th edge, data_out=0xA5, par_err=0, frame_cnt=1, sync_lock high for 9 cycles.
2. **Parity error.** Same stream with parity 1. Required: data_out=0xA5, par_err=1, valid pulses, frame_cnt stays 0.
3. **Hunt through noise and overlap.** Send 0,0,1,0,1,1, then 0x3C (parity 0). Required: lock on the 6th bit, data_out=0x3C, par_err=0.
4. **ce gaps.** Repeat scenario 1 with ce=0 for 3 cycles after payload bit 4, and ce=0 for 2 cycles before the parity bit. Required: identical data_out, par_err and frame_cnt; valid still exactly one cycle wide.
5. **Reset mid-frame.** Assert rst after payload bit 5, for 1 cycle, between edges. Required: outputs go to 0 immediately, state=HUNT, no valid pulse. A following complete 0x5A frame gives data_out=0x5A and frame_cnt=1.
6. **Wrap and back-to-back.** Send 256 consecutive good 0xFF frames (parity 0) with no gap bits. Required: 256 valid pulses, frame_cnt returns to 0, no frame missed.
